seven_seg_capture: RTL and testbench

Capture receiver for the multiplexed two-digit seven-segment bus (active-low digit enables plus active-low segments a–g). It samples each enabled digit after its enable has settled, decodes segment patterns back to decimal digits, and reassembles the 8-bit value. Once the same value has been seen in consecutive frames, it publishes it with a one-cycle valid strobe. It sits on the display-side pins for loopback self-test and for bench scoreboarding of the score display.

---
 rtl/seven_seg_capture.sv | 238 +++++++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - two-digit multiplexed seven-segment bus capture receiver
// Optional: define SEVSEG_CAPTURE_ERRCNT_EN to add the saturating err_count output.
module seven_seg_capture #(
  parameter int SETTLE_CYCLES  = 1024,
  parameter int FRAME_MATCH    = 2,
  parameter int TIMEOUT_CYCLES = 2097152
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [7:0] en_in,
  output logic [7:0] number,
  output logic       blank,
  output logic       valid,
  output logic       err
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_TERM = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_PRE  = SW'(SETTLE_CYCLES - 2);
  localparam logic [21:0]   TO_TERM     = 22'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    MATCH_TERM  = 3'(FRAME_MATCH);

  typedef enum logic {SEEK = 1'b0, HAVE0 = 1'b1} state_t;

  logic [7:0]    r_en_prev;
  logic [SW-1:0] r_settle;
  logic          r_smp_vld, r_smp_dig, r_smp_ill;
  logic [6:0]    r_smp_seg;
  state_t        r_state, w_state_next;
  logic [21:0]   r_to;
  logic [3:0]    r_ones_val;
  logic          r_ones_blank;
  logic          r_cand_vld, r_cand_blank, r_prev_blank;
  logic [7:0]    r_cand, r_prev_cand;
  logic [2:0]    r_match, w_match_next;

  logic       w_sel0, w_sel1, w_idle, w_settled, w_timeout;
  logic [3:0] w_dec_val;
  logic       w_dec_blank, w_dec_bad;
  logic       w_err, w_clr_match, w_load_ones, w_frame_ok, w_to_clr, w_publish;
  logic [6:0] w_sum7;
  logic [7:0] w_cand;

  assign w_sel0    = (en_in == 8'hFE);
  assign w_sel1    = (en_in == 8'hFD);
  assign w_idle    = (en_in == 8'hFF);
  // A changing enable in the terminal cycle fails the stability test and cancels the sample.
  assign w_settled = (en_in == r_en_prev) && (r_settle == SETTLE_PRE);
  assign w_timeout = (r_state == HAVE0) && (r_to == TO_TERM);

  // Settle counter: restarts on any enable change, saturates at its terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_prev <= 8'hFF;
      r_settle  <= '0;
    end else begin
      r_en_prev <= en_in;
      if (en_in != r_en_prev)
        r_settle <= '0;
      else if (r_settle != SETTLE_TERM)
        r_settle <= r_settle + 1'b1;
    end
  end

  // Sample register: one capture per enable period, illegal patterns flagged once settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp_vld <= 1'b0;
      r_smp_dig <= 1'b0;
      r_smp_ill <= 1'b0;
      r_smp_seg <= 7'h7F;
    end else begin
      r_smp_vld <= w_settled && (w_sel0 || w_sel1);
      r_smp_dig <= w_sel1;
      r_smp_ill <= w_settled && !(w_sel0 || w_sel1 || w_idle);
      r_smp_seg <= seg_in;
    end
  end

  // Segment pattern decode of the registered sample (active-low, [6]=a).
  always_comb begin
    w_dec_val   = 4'd0;
    w_dec_blank = 1'b0;
    w_dec_bad   = 1'b0;
    case (r_smp_seg)
      7'b0000001: w_dec_val = 4'd0;
      7'b1001111: w_dec_val = 4'd1;
      7'b0010010: w_dec_val = 4'd2;
      7'b0000110: w_dec_val = 4'd3;
      7'b1001100: w_dec_val = 4'd4;
      7'b0100100: w_dec_val = 4'd5;
      7'b0100000: w_dec_val = 4'd6;
      7'b0001111: w_dec_val = 4'd7;
      7'b0000000: w_dec_val = 4'd8;
      7'b0000100: w_dec_val = 4'd9;
      7'b1111111: w_dec_blank = 1'b1;
      default:    w_dec_bad = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SEEK;
    else        r_state <= w_state_next;
  end

  // FSM next state: any digit-1 sample or error ends the frame attempt.
  always_comb begin
    w_state_next = r_state;
    if (r_smp_ill)
      w_state_next = SEEK;
    else if (r_smp_vld)
      w_state_next = (!w_dec_bad && !r_smp_dig) ? HAVE0 : SEEK;
    else if (w_timeout)
      w_state_next = SEEK;
  end

  // FSM outputs: capture strobes, frame completion and error sources.
  always_comb begin
    w_err       = 1'b0;
    w_clr_match = 1'b0;
    w_load_ones = 1'b0;
    w_frame_ok  = 1'b0;
    w_to_clr    = 1'b0;
    if (r_smp_ill) begin
      w_err       = 1'b1;
      w_clr_match = 1'b1;
    end else if (r_smp_vld) begin
      if (w_dec_bad) begin
        w_err = 1'b1;
      end else if (!r_smp_dig) begin
        w_load_ones = 1'b1;
        w_to_clr    = 1'b1;
      end else if (r_state == HAVE0) begin
        if (w_dec_blank != r_ones_blank) begin
          w_err       = 1'b1;
          w_clr_match = 1'b1;
        end else begin
          w_frame_ok = 1'b1;
        end
      end
    end else if (w_timeout) begin
      w_err = 1'b1;
    end
  end

  // Ones digit holding register and digit-0 to digit-1 timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ones_val   <= 4'd0;
      r_ones_blank <= 1'b0;
      r_to         <= '0;
    end else begin
      if (w_load_ones) begin
        r_ones_val   <= w_dec_val;
        r_ones_blank <= w_dec_blank;
      end
      if (w_to_clr || r_state == SEEK)
        r_to <= '0;
      else if (r_to != '1)
        r_to <= r_to + 1'b1;
    end
  end

  assign w_sum7 = {3'b000, w_dec_val} * 7'd10 + {3'b000, r_ones_val};
  assign w_cand = w_dec_blank ? 8'hFF : {1'b0, w_sum7};

  // Compose register: candidate value of a completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand_vld   <= 1'b0;
      r_cand       <= 8'hFF;
      r_cand_blank <= 1'b0;
    end else begin
      r_cand_vld   <= w_frame_ok;
      r_cand       <= w_cand;
      r_cand_blank <= w_dec_blank;
    end
  end

  // Match count: consecutive identical candidates, saturating at the confirm threshold.
  always_comb begin
    w_match_next = r_match;
    if (w_clr_match)
      w_match_next = 3'd0;
    else if (r_cand_vld) begin
      if (r_match != 3'd0 && r_cand == r_prev_cand && r_cand_blank == r_prev_blank)
        w_match_next = (r_match == MATCH_TERM) ? r_match : r_match + 3'd1;
      else
        w_match_next = 3'd1;
    end
  end

  // An error raised in the same cycle wins over publishing.
  assign w_publish = r_cand_vld && !w_clr_match && !w_err && (w_match_next == MATCH_TERM) &&
                     (r_cand != number || r_cand_blank != blank);

  // Compare/publish register and registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match      <= 3'd0;
      r_prev_cand  <= 8'hFF;
      r_prev_blank <= 1'b0;
      number       <= 8'hFF;
      blank        <= 1'b1;
      valid        <= 1'b0;
      err          <= 1'b0;
    end else begin
      r_match <= w_match_next;
      if (r_cand_vld) begin
        r_prev_cand  <= r_cand;
        r_prev_blank <= r_cand_blank;
      end
      if (w_publish) begin
        number <= r_cand;
        blank  <= r_cand_blank;
      end
      valid <= w_publish;
      err   <= w_err;
    end
  end

`ifdef SEVSEG_CAPTURE_ERRCNT_EN
  // Error counter, aligned with the err pulse and saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= 8'd0;
    else if (w_err && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed self-checking bench for seven_seg_capture
module tb_seven_seg_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'h7F;
  logic [7:0] en_in = 8'hFF;
  logic [7:0] number;
  logic       blank, valid, err;
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
  logic [7:0] err_count;
`endif

  seven_seg_capture #(
    .SETTLE_CYCLES(4), .FRAME_MATCH(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .en_in(en_in),
    .number(number), .blank(blank), .valid(valid), .err(err)
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // Segment codes 0..9, active-low, [6]=a.
  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int valid_cyc = 0;
  int err_cyc = 0;
  int d1_start = 0;
  int d0_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
    end
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  // Called at a falling edge; holds the bus for n cycles.
  task automatic drive(input logic [7:0] en, input logic [6:0] seg, input int n);
    en_in  = en;
    seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [6:0] s0, input logic [6:0] s1);
    d0_start = cyc;
    drive(8'hFE, s0, 6);
    d1_start = cyc;
    drive(8'hFD, s1, 6);
    drive(8'hFF, 7'h7F, 6);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en_in = 8'hFF;
    seg_in = 7'h7F;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (number !== 8'hFF) begin failures++; $display("FAIL reset_number got=%h exp=ff", number); end
    checks++; if (blank !== 1'b1) begin failures++; $display("FAIL reset_blank got=%b exp=1", blank); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_toggle();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < 20; i++) begin
      drive(8'hFE, seg_tab[1], 2);
      drive(8'hFD, seg_tab[2], 2);
    end
    drive(8'hFF, 7'h7F, 6);
    checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL toggle_valid got=%0d exp=%0d", valid_cnt, v0); end
    checks++; if (err_cnt !== e0) begin failures++; $display("FAIL toggle_err got=%0d exp=%0d", err_cnt, e0); end
    checks++; if (number !== 8'hFF) begin failures++; $display("FAIL toggle_number got=%h exp=ff", number); end
  endtask

  task automatic test_publish();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(seg_tab[3], seg_tab[5]);
    checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL pub_first_frame got=%0d exp=%0d", valid_cnt, v0); end
    send_frame(seg_tab[3], seg_tab[5]);
    checks++; if (valid_cnt !== v0 + 1) begin failures++; $display("FAIL pub_valid got=%0d exp=%0d", valid_cnt, v0 + 1); end
    checks++; if (number !== 8'd53) begin failures++; $display("FAIL pub_number got=%0d exp=53", number); end
    checks++; if (blank !== 1'b0) begin failures++; $display("FAIL pub_blank got=%b exp=0", blank); end
    checks++; if (valid_cyc !== d1_start + 6) begin failures++; $display("FAIL pub_latency got=%0d exp=%0d", valid_cyc, d1_start + 6); end
    checks++; if (err_cnt !== e0) begin failures++; $display("FAIL pub_err got=%0d exp=%0d", err_cnt, e0); end
    send_frame(seg_tab[3], seg_tab[5]);
    checks++; if (valid_cnt !== v0 + 1) begin failures++; $display("FAIL pub_repeat got=%0d exp=%0d", valid_cnt, v0 + 1); end
  endtask

  task automatic test_blank();
    int v0;
    v0 = valid_cnt;
    send_frame(7'h7F, 7'h7F);
    send_frame(7'h7F, 7'h7F);
    checks++; if (valid_cnt !== v0 + 1) begin failures++; $display("FAIL blank_valid got=%0d exp=%0d", valid_cnt, v0 + 1); end
    checks++; if (number !== 8'hFF) begin failures++; $display("FAIL blank_number got=%h exp=ff", number); end
    checks++; if (blank !== 1'b1) begin failures++; $display("FAIL blank_flag got=%b exp=1", blank); end
  endtask

  task automatic test_bad_seg();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(7'b1111110, seg_tab[0]);
    checks++; if (err_cnt !== e0 + 1) begin failures++; $display("FAIL badseg_err got=%0d exp=%0d", err_cnt, e0 + 1); end
    checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL badseg_valid got=%0d exp=%0d", valid_cnt, v0); end
    send_frame(seg_tab[7], seg_tab[0]);
    send_frame(seg_tab[7], seg_tab[0]);
    checks++; if (valid_cnt !== v0 + 1) begin failures++; $display("FAIL badseg_recover got=%0d exp=%0d", valid_cnt, v0 + 1); end
    checks++; if (number !== 8'd7) begin failures++; $display("FAIL badseg_number got=%0d exp=7", number); end
    checks++; if (blank !== 1'b0) begin failures++; $display("FAIL badseg_blank got=%b exp=0", blank); end
  endtask

  task automatic test_errors();
    int v0, e0;
    do_reset();
    v0 = valid_cnt; e0 = err_cnt;
    drive(8'hFC, 7'h7F, 6);
    drive(8'hFF, 7'h7F, 4);
    checks++; if (err_cnt !== e0 + 1) begin failures++; $display("FAIL illegal_en_err got=%0d exp=%0d", err_cnt, e0 + 1); end
    d0_start = cyc;
    drive(8'hFE, seg_tab[4], 6);
    drive(8'hFF, 7'h7F, 34);
    checks++; if (err_cnt !== e0 + 1) begin failures++; $display("FAIL timeout_early got=%0d exp=%0d", err_cnt, e0 + 1); end
    drive(8'hFF, 7'h7F, 40);
    checks++; if (err_cnt !== e0 + 2) begin failures++; $display("FAIL timeout_err got=%0d exp=%0d", err_cnt, e0 + 2); end
    checks++; if (err_cyc < d0_start + 64 || err_cyc > d0_start + 72) begin
      failures++; $display("FAIL timeout_when got=%0d exp=%0d..%0d", err_cyc, d0_start + 64, d0_start + 72);
    end
    checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL errors_valid got=%0d exp=%0d", valid_cnt, v0); end
`ifdef SEVSEG_CAPTURE_ERRCNT_EN
    checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL err_count got=%0d exp=2", err_count); end
`endif
  endtask

  task automatic test_reset_mid();
    int v0;
    send_frame(seg_tab[2], seg_tab[4]);
    send_frame(seg_tab[2], seg_tab[4]);
    checks++; if (number !== 8'd42) begin failures++; $display("FAIL mid_setup got=%0d exp=42", number); end
    drive(8'hFE, seg_tab[2], 6);
    rst_n = 1'b0;
    #1;
    checks++; if (number !== 8'hFF) begin failures++; $display("FAIL mid_rst_number got=%h exp=ff", number); end
    checks++; if (blank !== 1'b1) begin failures++; $display("FAIL mid_rst_blank got=%b exp=1", blank); end
    checks++; if (valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL mid_rst_pulses got=%b%b exp=00", valid, err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_cnt;
    drive(8'hFD, seg_tab[4], 6);
    drive(8'hFF, 7'h7F, 6);
    checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL mid_stale_digit1 got=%0d exp=%0d", valid_cnt, v0); end
    send_frame(seg_tab[2], seg_tab[4]);
    checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL mid_one_frame got=%0d exp=%0d", valid_cnt, v0); end
    send_frame(seg_tab[2], seg_tab[4]);
    checks++; if (valid_cnt !== v0 + 1) begin failures++; $display("FAIL mid_two_frames got=%0d exp=%0d", valid_cnt, v0 + 1); end
    checks++; if (number !== 8'd42) begin failures++; $display("FAIL mid_number got=%0d exp=42", number); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_toggle();
    test_publish();
    test_blank();
    test_bad_seg();
    test_errors();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
